// File: rtl/path_test_pkg.sv
// path_test_pkg: shared types and constants for the path test sequencer.
// Holds the FSM state encoding, counter width, MISR polynomial/seed and a
// saturating increment helper used by every 8-bit counter in the block.
package path_test_pkg;

    localparam int CNT_W  = 8;
    localparam int MISR_W = 16;

    // x^16 + x^12 + x^5 + 1, Galois feedback taps
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/path_test_misr.sv
// path_test_misr: 16-bit Galois MISR compacting the sampled path output.
// Reloads the seed on 'seed', shifts one bit per cycle while 'shift_en'.
module path_test_misr
    import path_test_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed,
    input  logic              shift_en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    logic fb;

    assign fb = sig[MISR_W-1] ^ din;

    // Seed on run start, otherwise shift in the sampled path output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= MISR_SEED;
        end else if (seed) begin
            sig <= MISR_SEED;
        end else if (shift_en) begin
            sig <= {sig[MISR_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
        end
    end

endmodule

// File: rtl/path_test_sequencer.sv
// path_test_sequencer: drives rise/fall transitions into a single path,
// measures the latency until the registered path output follows, and
// reports failures, worst latency and a pass flag per run.
// Optional feature: define PATH_TEST_MISR_EN to add a 16-bit 'signature'
// output compacting the path output over every WAIT cycle.
module path_test_sequencer
    import path_test_pkg::*;
#(
    parameter int INVERT     = 0,
    parameter int SETTLE_MAX = 15,
    parameter int REPEAT     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             po_i,
    output logic             pi_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] max_lat
`ifdef PATH_TEST_MISR_EN
    ,
    output logic [MISR_W-1:0] signature
`endif
);

    localparam logic             INV         = (INVERT != 0);
    localparam logic [CNT_W-1:0] SETTLE      = CNT_W'(SETTLE_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_MAX - 1);
    localparam logic [CNT_W-1:0] REP         = CNT_W'(REPEAT);

    state_t           state, state_nxt;
    logic             po_q;
    logic             pass_q;
    logic [CNT_W-1:0] tmr;       // settle count in INIT, latency in WAIT
    logic [CNT_W-1:0] iter;

    logic expected, match, init_last, timeout, last_iter, run_go, kill;

    assign expected  = pi_o ^ INV;
    assign match     = (po_q == expected);
    assign init_last = (tmr == SETTLE_LAST);
    assign timeout   = (tmr >= SETTLE);
    // Only a falling launch closes an iteration
    assign last_iter = !pi_o && (sat_inc(iter) == REP);
    assign run_go    = (state == ST_IDLE) && start && !abort;
    assign kill      = (state != ST_IDLE) && abort;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (run_go) state_nxt = ST_INIT;
                ST_INIT:   if (init_last) state_nxt = match ? ST_LAUNCH : ST_FIN;
                ST_LAUNCH: state_nxt = ST_WAIT;
                ST_WAIT:   if (match || timeout) state_nxt = ST_NEXT;
                ST_NEXT:   state_nxt = last_iter ? ST_FIN : ST_LAUNCH;
                ST_FIN:    state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Status outputs; done/pass are valid together during FIN
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_FIN) && !abort;
        pass = done ? (fail_cnt == '0) : pass_q;
    end

    // Path drive, sampling, counters and run results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pi_o     <= 1'b0;
            po_q     <= 1'b0;
            pass_q   <= 1'b0;
            tmr      <= '0;
            iter     <= '0;
            fail_cnt <= '0;
            max_lat  <= '0;
        end else begin
            po_q <= po_i;
            if (kill) begin
                pi_o   <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (run_go) begin
                            pi_o     <= 1'b0;
                            pass_q   <= 1'b0;
                            tmr      <= '0;
                            iter     <= '0;
                            fail_cnt <= '0;
                            max_lat  <= '0;
                        end
                    end
                    ST_INIT: begin
                        if (!init_last)  tmr      <= sat_inc(tmr);
                        else if (!match) fail_cnt <= CNT_W'(1);
                    end
                    ST_LAUNCH: begin
                        pi_o <= ~pi_o;
                        tmr  <= '0;
                    end
                    ST_WAIT: begin
                        if (match) begin
                            if (tmr > max_lat) max_lat <= tmr;
                        end else if (timeout) begin
                            fail_cnt <= sat_inc(fail_cnt);
                        end else begin
                            tmr <= sat_inc(tmr);
                        end
                    end
                    ST_NEXT: begin
                        if (!pi_o) iter <= sat_inc(iter);
                    end
                    ST_FIN: begin
                        pass_q <= (fail_cnt == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PATH_TEST_MISR_EN
    path_test_misr u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .seed     (run_go),
        .shift_en (state == ST_WAIT),
        .din      (po_q),
        .sig      (signature)
    );
`endif

endmodule
